// File: rtl/platform_field.sv
// ---------------------------------------------------------------------------
// platform_field
//   Platform generator and renderer for the Doodle Jump playfield.
//   N_PLAT platform centres (X, Y) live in registers. An IDLE/INIT/SCROLL
//   FSM walks one slot per cycle. INIT re-places every platform on a fixed
//   vertical pitch at a random X. SCROLL moves every platform down and
//   respawns at the top any platform that falls off the bottom. Random X
//   values come from a 16-bit Fibonacci LFSR.
//
// Ports
//   Clk         system clock
//   Reset       asynchronous, active-low reset
//   init        one-cycle pulse: re-place all platforms
//   frame_tick  one-cycle pulse per frame: request a scroll
//   scroll_amt  pixels to move down; sampled on every SCROLL cycle
//   DrawX/DrawY current pixel
//   BallX/BallY ball centre
//   Ball_size   ball half-size
//   plat_on     pixel lies inside some platform (combinational)
//   plat_idx    lowest index of a hit platform, 0 when plat_on=0
//   land        ball bottom edge overlaps some platform (combinational)
//   busy        FSM is in INIT or SCROLL (registered)
// ---------------------------------------------------------------------------
module platform_field #(
  parameter int          N_PLAT      = 16,
  parameter int          COORD_W     = 10,
  parameter int          H_RES       = 640,
  parameter int          V_RES       = 480,
  parameter int          PLAT_HALF_W = 16,
  parameter int          PLAT_HALF_H = 4,
  parameter int          SPACING     = 30,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      init,
  input  logic                      frame_tick,
  input  logic [COORD_W-1:0]        scroll_amt,
  input  logic [COORD_W-1:0]        DrawX,
  input  logic [COORD_W-1:0]        DrawY,
  input  logic [COORD_W-1:0]        BallX,
  input  logic [COORD_W-1:0]        BallY,
  input  logic [COORD_W-1:0]        Ball_size,
  output logic                      plat_on,
  output logic [$clog2(N_PLAT)-1:0] plat_idx,
  output logic                      land,
  output logic                      busy
);

  localparam int IDX_W = $clog2(N_PLAT);

  localparam logic [COORD_W-1:0] X_MID   = COORD_W'(H_RES / 2);
  localparam logic [COORD_W-1:0] X_MIN   = COORD_W'(PLAT_HALF_W);
  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(H_RES - 1 - PLAT_HALF_W);
  localparam logic [COORD_W-1:0] AMT_MAX = COORD_W'(SPACING);
  localparam logic [COORD_W:0]   V_LIM   = (COORD_W+1)'(V_RES);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_PLAT - 1);

  // Hit-test constants, signed so the edge compares never underflow.
  localparam logic signed [COORD_W:0]   HW1 = (COORD_W+1)'(PLAT_HALF_W);
  localparam logic signed [COORD_W:0]   HH1 = (COORD_W+1)'(PLAT_HALF_H);
  localparam logic signed [COORD_W+1:0] HW2 = (COORD_W+2)'(PLAT_HALF_W);
  localparam logic signed [COORD_W+1:0] HH2 = (COORD_W+2)'(PLAT_HALF_H);

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_SCROLL} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               pend_reg, pend_next;
  logic               busy_reg;
  logic [15:0]        lfsr_reg, lfsr_next;

  logic [COORD_W-1:0] x_reg [N_PLAT];
  logic [COORD_W-1:0] y_reg [N_PLAT];

  logic               slot_we;
  logic [COORD_W-1:0] x_new, y_new;

  // ---------------- state register ----------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      pend_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      lfsr_reg  <= LFSR_SEED;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      pend_reg  <= pend_next;
      busy_reg  <= (state_next != ST_IDLE);
      lfsr_reg  <= lfsr_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    pend_next  = pend_reg;
    case (state_reg)
      ST_IDLE: begin
        if (init) begin
          state_next = ST_INIT;
          idx_next   = '0;
        end else if (frame_tick || pend_reg) begin
          state_next = ST_SCROLL;
          idx_next   = '0;
          pend_next  = 1'b0;
        end
      end
      ST_INIT: begin
        if (frame_tick) pend_next = 1'b1;
        if (init) begin
          idx_next = '0;                 // restart from slot 0
        end else if (idx_reg == IDX_LAST) begin
          state_next = ST_IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      ST_SCROLL: begin
        if (init) begin
          // A re-place makes the queued scroll meaningless.
          state_next = ST_INIT;
          idx_next   = '0;
          pend_next  = 1'b0;
        end else begin
          if (frame_tick) pend_next = 1'b1;
          if (idx_reg == IDX_LAST) begin
            state_next = ST_IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // ---------------- slot update / LFSR datapath ----------------
  logic [15:0]        lfsr_adv;
  logic [COORD_W-1:0] cand_raw, cand, cur_y, amt;
  logic [COORD_W:0]   sum;
  logic               consume;

  always_comb begin
    lfsr_adv = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    cand_raw = lfsr_adv[COORD_W-1:0];
    if (cand_raw < X_MIN)      cand = X_MIN;
    else if (cand_raw > X_MAX) cand = X_MAX;
    else                       cand = cand_raw;

    cur_y = y_reg[idx_reg];
    amt   = (scroll_amt > AMT_MAX) ? AMT_MAX : scroll_amt;
    sum   = {1'b0, cur_y} + {1'b0, amt};

    slot_we = 1'b0;
    consume = 1'b0;
    x_new   = x_reg[idx_reg];
    y_new   = cur_y;
    // An init pulse during a busy phase only restarts; no slot is written.
    if (state_reg == ST_INIT && !init) begin
      slot_we = 1'b1;
      consume = 1'b1;
      x_new   = cand;
      y_new   = COORD_W'(SPACING * (int'(idx_reg) + 1));
    end else if (state_reg == ST_SCROLL && !init) begin
      slot_we = 1'b1;
      if (sum >= V_LIM) begin
        consume = 1'b1;
        x_new   = cand;
        y_new   = COORD_W'(sum - V_LIM);
      end else begin
        y_new = sum[COORD_W-1:0];
      end
    end
    lfsr_next = consume ? lfsr_adv : lfsr_reg;
  end

  // ---------------- platform registers ----------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < N_PLAT; i++) begin
        x_reg[i] <= X_MID;
        y_reg[i] <= COORD_W'(SPACING * (i + 1));
      end
    end else if (slot_we) begin
      x_reg[idx_reg] <= x_new;
      y_reg[idx_reg] <= y_new;
    end
  end

  // ---------------- per-slot pixel / landing tests ----------------
  logic [N_PLAT-1:0]          hit_vec, land_vec;
  logic signed [COORD_W+1:0]  ball_bot, x_lim;

  assign ball_bot = $signed({2'b00, BallY}) + $signed({2'b00, Ball_size});
  assign x_lim    = HW2 + $signed({2'b00, Ball_size});

  genvar gi;
  generate
    for (gi = 0; gi < N_PLAT; gi++) begin : g_slot
      logic signed [COORD_W:0]   hx, hy;
      logic signed [COORD_W+1:0] ly_lo, ly_hi, lx;

      assign hx = $signed({1'b0, DrawX}) - $signed({1'b0, x_reg[gi]});
      assign hy = $signed({1'b0, DrawY}) - $signed({1'b0, y_reg[gi]});
      assign hit_vec[gi] = (hx >= -HW1) && (hx <= HW1) && (hy >= -HH1) && (hy <= HH1);

      assign ly_lo = $signed({2'b00, y_reg[gi]}) - HH2;
      assign ly_hi = $signed({2'b00, y_reg[gi]}) + HH2;
      assign lx    = $signed({2'b00, BallX}) - $signed({2'b00, x_reg[gi]});
      assign land_vec[gi] = (ball_bot >= ly_lo) && (ball_bot <= ly_hi) &&
                            (lx >= -x_lim) && (lx <= x_lim);
    end
  endgenerate

  // ---------------- outputs ----------------
  always_comb begin
    plat_idx = '0;
    for (int i = N_PLAT - 1; i >= 0; i--) begin
      if (hit_vec[i]) plat_idx = IDX_W'(i);
    end
  end

  assign plat_on = |hit_vec;
  assign land    = |land_vec;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_platform_field.sv
module tb_platform_field;
  localparam int N = 16;

  logic       Clk = 1'b0;
  logic       Reset, init, frame_tick;
  logic [9:0] scroll_amt, DrawX, DrawY, BallX, BallY, Ball_size;
  logic       plat_on;
  logic [3:0] plat_idx;
  logic       land, busy;

  always #5 Clk = ~Clk;

  platform_field dut (
    .Clk(Clk), .Reset(Reset), .init(init), .frame_tick(frame_tick),
    .scroll_amt(scroll_amt), .DrawX(DrawX), .DrawY(DrawY),
    .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size),
    .plat_on(plat_on), .plat_idx(plat_idx), .land(land), .busy(busy)
  );

  int passed = 0;
  int total  = 0;

  // ---------------- reference model (whole-operation granularity) ----------------
  int          mx [N];
  int          my [N];
  logic [15:0] mlfsr;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int next_x();
    mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    next_x = int'(mlfsr[9:0]);
    if (next_x < 16)  next_x = 16;
    if (next_x > 623) next_x = 623;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mx[i] = 320; my[i] = 30 * (i + 1); end
    mlfsr = 16'hACE1;
  endtask

  task automatic model_init();
    for (int i = 0; i < N; i++) begin mx[i] = next_x(); my[i] = 30 * (i + 1); end
  endtask

  task automatic model_scroll(input int amt);
    int s;
    for (int i = 0; i < N; i++) begin
      s = my[i] + ((amt > 30) ? 30 : amt);
      if (s >= 480) begin my[i] = s - 480; mx[i] = next_x(); end
      else my[i] = s;
    end
  endtask

  function automatic int m_hit(input int px, input int py);
    for (int i = 0; i < N; i++)
      if (iabs(px - mx[i]) <= 16 && iabs(py - my[i]) <= 4) return i;
    return -1;
  endfunction

  function automatic int m_land(input int bx, input int by, input int bs);
    for (int i = 0; i < N; i++)
      if (by + bs >= my[i] - 4 && by + bs <= my[i] + 4 && iabs(bx - mx[i]) <= 16 + bs) return 1;
    return 0;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic probe_const(input string name, input int px, input int py, input int on, input int idx);
    @(negedge Clk);
    DrawX = 10'(px); DrawY = 10'(py);
    #1;
    chk({name, "_on"},  int'(plat_on),  on);
    chk({name, "_idx"}, int'(plat_idx), idx);
  endtask

  task automatic probe_model(input string name, input int px, input int py);
    int e;
    e = m_hit(px, py);
    probe_const(name, px, py, (e >= 0) ? 1 : 0, (e >= 0) ? e : 0);
  endtask

  task automatic probe_all(input string tag);
    for (int i = 0; i < N; i++) begin
      probe_model({tag, "_ctr"}, mx[i], my[i]);
      probe_model({tag, "_corner"}, mx[i] + 16, my[i] + 4);
      probe_model({tag, "_outx"}, mx[i] + 17, my[i]);
    end
  endtask

  // Count busy cycles after a command pulse; bounded wait.
  task automatic wait_busy(input string name, input int exp_len);
    int cnt = 0;
    int guard = 0;
    while (busy && guard < 200) begin
      cnt++; guard++;
      @(negedge Clk);
    end
    chk(name, cnt, exp_len);
  endtask

  task automatic do_init();
    @(negedge Clk) init = 1'b1;
    @(negedge Clk) init = 1'b0;
    wait_busy("init_busy_len", 16);
    model_init();
    $display("txn init done");
  endtask

  task automatic do_scroll(input int amt);
    scroll_amt = 10'(amt);
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) frame_tick = 1'b0;
    wait_busy("scroll_busy_len", 16);
    model_scroll(amt);
    $display("txn scroll amt=%0d done", amt);
  endtask

  // frame_tick pulses during a scroll (at busy cycles 2, 5, 8) must queue exactly one more.
  task automatic pend_test(input int amt, input int nticks);
    int seq [45];
    int ones = 0;
    int late = 0;
    scroll_amt = 10'(amt);
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) frame_tick = 1'b0;
    for (int k = 0; k < 45; k++) begin
      seq[k] = int'(busy);
      frame_tick = (k == 2) || (k == 5 && nticks > 1) || (k == 8 && nticks > 2);
      @(negedge Clk);
    end
    frame_tick = 1'b0;
    for (int k = 0; k < 45; k++) begin
      ones += seq[k];
      if (k >= 33) late += seq[k];
    end
    chk("pend_first_busy", seq[15], 1);
    chk("pend_gap",        seq[16], 0);
    chk("pend_second",     seq[17], 1);
    chk("pend_total_busy", ones, 32);
    chk("pend_no_third",   late, 0);
    model_scroll(amt);
    model_scroll(amt);
    $display("txn pend test ticks=%0d amt=%0d done", nticks, amt);
  endtask

  // ---------------- table vectors (reset state: X=320, Y=30*(i+1)) ----------------
  typedef struct {
    int dx, dy, bx, by, bs;
    int on, idx, lnd;
  } vec_t;
  vec_t tbl [12];

  initial begin
    int e, j, bx, by, bs;

    tbl[0]  = '{0,   0,   0,   0,   0,  0, 0,  0};
    tbl[1]  = '{320, 30,  320, 20,  6,  1, 0,  1};
    tbl[2]  = '{304, 26,  342, 290, 6,  1, 0,  1};
    tbl[3]  = '{303, 30,  343, 290, 6,  0, 0,  0};
    tbl[4]  = '{336, 34,  320, 283, 6,  1, 0,  0};
    tbl[5]  = '{320, 35,  320, 305, 0,  0, 0,  0};
    tbl[6]  = '{320, 480, 320, 300, 4,  1, 15, 1};
    tbl[7]  = '{320, 60,  298, 200, 0,  1, 1,  0};
    tbl[8]  = '{320, 45,  320, 206, 0,  0, 0,  1};
    tbl[9]  = '{337, 90,  336, 214, 0,  0, 0,  1};
    tbl[10] = '{320, 476, 337, 214, 0,  1, 15, 0};
    tbl[11] = '{320, 454, 320, 465, 10, 1, 14, 0};

    Reset = 1'b0; init = 1'b0; frame_tick = 1'b0; scroll_amt = '0;
    DrawX = '0; DrawY = '0; BallX = '0; BallY = '0; Ball_size = '0;
    model_reset();
    repeat (3) @(negedge Clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_plat_on_00", int'(plat_on), 0);
    @(negedge Clk) Reset = 1'b1;

    for (int t = 0; t < 12; t++) begin
      @(negedge Clk);
      DrawX = 10'(tbl[t].dx); DrawY = 10'(tbl[t].dy);
      BallX = 10'(tbl[t].bx); BallY = 10'(tbl[t].by); Ball_size = 10'(tbl[t].bs);
      #1;
      chk("tbl_plat_on",  int'(plat_on),  tbl[t].on);
      chk("tbl_plat_idx", int'(plat_idx), tbl[t].idx);
      chk("tbl_land",     int'(land),     tbl[t].lnd);
      $display("txn vector %0d draw=(%0d,%0d) ball=(%0d,%0d,%0d)", t,
               tbl[t].dx, tbl[t].dy, tbl[t].bx, tbl[t].by, tbl[t].bs);
    end

    // First init: slot 0 lands at X=451, Y=30.
    do_init();
    probe_const("init_x0_a", 435, 26, 1, 0);
    probe_const("init_x0_b", 467, 34, 1, 0);
    probe_const("init_x0_c", 434, 30, 0, 0);
    probe_const("init_x0_d", 451, 35, 0, 0);

    // Slot 14 to Y=470, then wrap to Y=5 with a fresh X; then clamped scroll.
    do_scroll(20);
    probe_all("s20");
    do_scroll(15);
    probe_const("wrap_y5", mx[14], 5, 1, 14);
    probe_all("s15");
    do_scroll(100);
    probe_all("s100");

    pend_test(7, 1);
    probe_all("pend1");
    pend_test(12, 3);
    probe_all("pend3");

    // Reset in the middle of an INIT.
    @(negedge Clk) init = 1'b1;
    @(negedge Clk) init = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("midreset_busy", int'(busy), 0);
    model_reset();
    probe_const("midreset_s0", 320, 30, 1, 0);
    probe_const("midreset_s15", 320, 480, 1, 15);
    probe_const("midreset_00", 0, 0, 0, 0);
    @(negedge Clk) Reset = 1'b1;
    $display("txn reset mid-init done");
    do_init();
    probe_const("reinit_x0_a", 435, 26, 1, 0);
    probe_const("reinit_x0_c", 434, 30, 0, 0);

    // Randomized operations against the model.
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0) do_init();
      else do_scroll(int'($urandom_range(0, 100)));
      for (int i = 0; i < N; i += 3) begin
        probe_model("rnd_ctr", mx[i], my[i]);
        probe_model("rnd_edge", mx[i] + 16, my[i] + 5);
      end
      for (int r = 0; r < 6; r++) begin
        j  = int'($urandom_range(0, N - 1));
        bs = int'($urandom_range(0, 10));
        bx = mx[j] + int'($urandom_range(0, 60)) - 30;
        by = my[j] - bs + int'($urandom_range(0, 12)) - 6;
        if (bx < 0) bx = 0;
        if (by < 0) by = 0;
        @(negedge Clk);
        BallX = 10'(bx); BallY = 10'(by); Ball_size = 10'(bs);
        #1;
        e = m_land(bx, by, bs);
        chk("rnd_land", int'(land), e);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
